// File: rtl/parity_frame_rx.sv
// Serial frame receiver: start bit, 4 data bits (LSB first), parity bit and stop bit.
// Recomputes parity over the nibble and reports it with error flags as a one-cycle valid pulse.
module parity_frame_rx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_ODD   = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_in,
    output logic [3:0] data_out,
    output logic       data_valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       busy
);

    // state  | meaning
    // IDLE   | line idle, waiting for a falling edge on rx_s
    // START  | half a bit period into the start bit, confirm it is still low
    // DATA   | sampling the four data bits, one per bit period
    // PARITY | sampling the parity bit
    // STOP   | sampling the stop bit, then latching nibble and flags
    // DONE   | data_valid cycle, back to IDLE next
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        DONE
    } state_t;

    localparam int             CW      = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [CW-1:0]  HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0]  FULL_M1 = CW'(CLKS_PER_BIT - 1);
    localparam logic           ODD     = (PARITY_ODD != 0);

    state_t        state;
    state_t        state_next;
    logic          sync1;
    logic          rx_s;
    logic          rx_prev;
    logic          fall;
    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [3:0]    shift;
    logic          par_bit;
    logic          cnt_zero;
    logic          load_half;
    logic          load_full;
    logic          shift_en;
    logic          par_en;
    logic          stop_en;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1   <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            sync1   <= rx_in;
            rx_s    <= sync1;
            rx_prev <= rx_s;
        end
    end

    assign fall     = rx_prev & ~rx_s;
    assign cnt_zero = (cnt == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load_half  = 1'b0;
        load_full  = 1'b0;
        shift_en   = 1'b0;
        par_en     = 1'b0;
        stop_en    = 1'b0;
        case (state)
            IDLE: begin
                if (fall) begin
                    load_half  = 1'b1;
                    state_next = START;
                end
            end
            START: begin
                if (cnt_zero) begin
                    if (rx_s) begin
                        state_next = IDLE;
                    end else begin
                        load_full  = 1'b1;
                        state_next = DATA;
                    end
                end
            end
            DATA: begin
                if (cnt_zero) begin
                    shift_en  = 1'b1;
                    load_full = 1'b1;
                    if (idx == 3'd3) begin
                        state_next = PARITY;
                    end
                end
            end
            PARITY: begin
                if (cnt_zero) begin
                    par_en     = 1'b1;
                    load_full  = 1'b1;
                    state_next = STOP;
                end
            end
            STOP: begin
                if (cnt_zero) begin
                    stop_en    = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt        <= '0;
            idx        <= '0;
            shift      <= '0;
            par_bit    <= 1'b0;
            data_out   <= '0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            if (load_half) begin
                cnt <= HALF_M1;
            end else if (load_full) begin
                cnt <= FULL_M1;
            end else if (!cnt_zero) begin
                cnt <= cnt - CW'(1);
            end

            if (load_half) begin
                idx <= '0;
            end else if (shift_en) begin
                idx <= idx + 3'd1;
            end

            if (shift_en) begin
                shift <= {rx_s, shift[3:1]};
            end
            if (par_en) begin
                par_bit <= rx_s;
            end
            // Flags only move when a complete frame lands, so false starts never disturb them.
            if (stop_en) begin
                data_out   <= shift;
                parity_err <= ((^shift) ^ ODD) != par_bit;
                frame_err  <= ~rx_s;
            end
        end
    end

    assign data_valid = (state == DONE);
    assign busy       = (state != IDLE);

endmodule

// File: tb/tb_parity_frame_rx.sv
// Directed bench for parity_frame_rx: even instance plus an odd-parity instance sharing the line.
module tb_parity_frame_rx;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx_in;
    logic [3:0] data_out;
    logic       data_valid;
    logic       parity_err;
    logic       frame_err;
    logic       busy;
    logic [3:0] o_data_out;
    logic       o_data_valid;
    logic       o_parity_err;
    logic       o_frame_err;
    logic       o_busy;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int dv_count = 0;
    int odv_count = 0;
    int base;
    int fall_cyc;
    logic busy_seen;

    logic [3:0] ev_data [32];
    logic       ev_pe   [32];
    logic       ev_fe   [32];
    int         ev_cyc  [32];
    logic [3:0] ev_odata[32];
    logic       ev_ope  [32];
    logic       ev_ofe  [32];

    parity_frame_rx #(.CLKS_PER_BIT(CPB), .PARITY_ODD(0)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_in     (rx_in),
        .data_out  (data_out),
        .data_valid(data_valid),
        .parity_err(parity_err),
        .frame_err (frame_err),
        .busy      (busy)
    );

    parity_frame_rx #(.CLKS_PER_BIT(CPB), .PARITY_ODD(1)) dut_odd (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_in     (rx_in),
        .data_out  (o_data_out),
        .data_valid(o_data_valid),
        .parity_err(o_parity_err),
        .frame_err (o_frame_err),
        .busy      (o_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (busy) busy_seen = 1'b1;
        if (data_valid && dv_count < 32) begin
            ev_data[dv_count] = data_out;
            ev_pe[dv_count]   = parity_err;
            ev_fe[dv_count]   = frame_err;
            ev_cyc[dv_count]  = cyc;
        end
        if (data_valid) dv_count++;
        if (o_data_valid && odv_count < 32) begin
            ev_odata[odv_count] = o_data_out;
            ev_ope[odv_count]   = o_parity_err;
            ev_ofe[odv_count]   = o_frame_err;
        end
        if (o_data_valid) odv_count++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic drive_bit(input logic b);
        rx_in = b;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [3:0] d, input logic p, input logic s);
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(d[i]);
        drive_bit(p);
        drive_bit(s);
    endtask

    task automatic idle(input int n);
        rx_in = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rx_in = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(5);
        check("rst_data", 32'(data_out), 32'h0);
        check("rst_valid", 32'(data_valid), 32'h0);
        check("rst_perr", 32'(parity_err), 32'h0);
        check("rst_ferr", 32'(frame_err), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_odd_busy", 32'(o_busy), 32'h0);

        // good even frame 4'hB, parity 1
        base = dv_count;
        fall_cyc = cyc;
        send_frame(4'hB, 1'b1, 1'b1);
        idle(20);
        check("good_count", 32'(dv_count - base), 32'd1);
        check("good_latency", 32'(ev_cyc[base] - fall_cyc), 32'd107);
        check("good_data", 32'(ev_data[base]), 32'hB);
        check("good_perr", 32'(ev_pe[base]), 32'h0);
        check("good_ferr", 32'(ev_fe[base]), 32'h0);
        check("good_odd_perr", 32'(ev_ope[base]), 32'h1);
        check("good_odd_data", 32'(ev_odata[base]), 32'hB);

        // parity error frame 4'h6 with parity 1
        base = dv_count;
        send_frame(4'h6, 1'b1, 1'b1);
        idle(10);
        check("perr_count", 32'(dv_count - base), 32'd1);
        check("perr_data", 32'(ev_data[base]), 32'h6);
        check("perr_perr", 32'(ev_pe[base]), 32'h1);
        check("perr_ferr", 32'(ev_fe[base]), 32'h0);
        check("perr_odd_perr", 32'(ev_ope[base]), 32'h0);
        check("perr_odd_ferr", 32'(ev_ofe[base]), 32'h0);

        // framing error, then line held low for three bit periods
        base = dv_count;
        send_frame(4'hF, 1'b0, 1'b0);
        rx_in = 1'b0;
        repeat (3 * CPB) @(posedge clk);
        #1;
        check("ferr_count", 32'(dv_count - base), 32'd1);
        check("ferr_data", 32'(ev_data[base]), 32'hF);
        check("ferr_perr", 32'(ev_pe[base]), 32'h0);
        check("ferr_ferr", 32'(ev_fe[base]), 32'h1);
        check("ferr_low_busy", 32'(busy), 32'h0);
        idle(20);
        check("ferr_rise_count", 32'(dv_count - base), 32'd1);

        // false start: 3 cycles low
        base = dv_count;
        busy_seen = 1'b0;
        rx_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        idle(40);
        check("fs_busy_seen", 32'(busy_seen), 32'h1);
        check("fs_busy_end", 32'(busy), 32'h0);
        check("fs_count", 32'(dv_count - base), 32'd0);
        check("fs_data", 32'(data_out), 32'hF);
        check("fs_ferr", 32'(frame_err), 32'h1);
        check("fs_perr", 32'(parity_err), 32'h0);

        // reset during data bit 2
        base = dv_count;
        drive_bit(1'b0);
        drive_bit(1'b0);
        drive_bit(1'b1);
        rx_in = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("mrst_data", 32'(data_out), 32'h0);
        check("mrst_ferr", 32'(frame_err), 32'h0);
        check("mrst_perr", 32'(parity_err), 32'h0);
        check("mrst_busy", 32'(busy), 32'h0);
        check("mrst_valid", 32'(data_valid), 32'h0);
        rst_n = 1'b1;
        idle(80);
        check("mrst_count", 32'(dv_count - base), 32'd0);
        base = dv_count;
        send_frame(4'h5, 1'b0, 1'b1);
        idle(10);
        check("post_count", 32'(dv_count - base), 32'd1);
        check("post_data", 32'(ev_data[base]), 32'h5);
        check("post_perr", 32'(ev_pe[base]), 32'h0);
        check("post_ferr", 32'(ev_fe[base]), 32'h0);

        // back-to-back frames with zero idle gap
        base = dv_count;
        send_frame(4'h3, 1'b0, 1'b1);
        send_frame(4'hC, 1'b0, 1'b1);
        send_frame(4'h0, 1'b0, 1'b1);
        idle(20);
        check("b2b_count", 32'(dv_count - base), 32'd3);
        check("b2b_gap1", 32'(ev_cyc[base + 1] - ev_cyc[base]), 32'd112);
        check("b2b_gap2", 32'(ev_cyc[base + 2] - ev_cyc[base + 1]), 32'd112);
        check("b2b_data0", 32'(ev_data[base]), 32'h3);
        check("b2b_data1", 32'(ev_data[base + 1]), 32'hC);
        check("b2b_data2", 32'(ev_data[base + 2]), 32'h0);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("b2b_perr%0d", k), 32'(ev_pe[base + k]), 32'h0);
            check($sformatf("b2b_ferr%0d", k), 32'(ev_fe[base + k]), 32'h0);
        end
        check("odd_total_count", 32'(odv_count), 32'(dv_count));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/parity_frame_rx.md
# parity_frame_rx

Serial frame receiver and parity checker that sits directly upstream of the 4-bit even-parity stage's consumers. It deserialises an asynchronous frame of 1 start bit, 4 data bits (LSB first), 1 parity bit and 1 stop bit from a single line. It recomputes parity over the received nibble, compares it with the received parity bit, and presents the nibble with error flags as a one-cycle valid pulse. The line idles high.

## Interface
Parameters:
- CLKS_PER_BIT, 16: clock cycles per serial bit period; must be even and ≥ 4.
- PARITY_ODD, 0: 0 = even parity (parity bit = XOR of data bits); 1 = odd parity (parity bit = inverted XOR).

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  reset; one clock; reset is synchronous and active-low.
- rx_in  input  1  asynchronous serial line; idle high.
- data_out  output  4  last received nibble; bit 0 is the first data bit on the line.
- data_valid  output  1  one-cycle pulse; data_out and the error flags are updated in the same cycle.
- parity_err  output  1  received parity bit did not match the computed parity.
- frame_err  output  1  stop bit was sampled low.
- busy  output  1  high from accepted start edge until return to IDLE.

## Operation
- rx_in passes through a 2-flop synchroniser, giving rx_s. A third flop holds the previous rx_s for edge detection. All synchroniser flops reset to 1.
- A single counter counts to CLKS_PER_BIT. Width is the ceiling of log2(CLKS_PER_BIT) plus 1.
- A 3-bit index tracks the data bit. A 4-bit shift register holds the data, shifting right with the new bit entering at bit 3.
- IDLE: on a falling edge of rx_s (previous 1, current 0), load the counter and go to START. busy goes high in the next cycle.
- START: wait CLKS_PER_BIT/2 cycles, then sample rx_s.
  - rx_s = 1: false start. Return to IDLE with no outputs changed.
  - rx_s = 0: go to DATA.
- DATA: sample every CLKS_PER_BIT cycles. Go to PARITY after 4 samples.
- PARITY: sample one bit period later. Store the parity bit.
- STOP: sample one bit period later. On the next cycle:
  - data_out = shift register.
  - parity_err = (XOR of data ^ PARITY_ODD) != parity bit.
  - frame_err = ~stop sample.
  - data_valid = 1.
  - Return to IDLE with busy = 0.
- After a frame_err, a new frame is accepted only after rx_s has been seen high and then falls again. This follows from the edge-detect rule.
- data_out, parity_err and frame_err hold their values until the next data_valid. They are never changed by a false start.
- Reset values: data_out = 0, data_valid = 0, parity_err = 0, frame_err = 0, busy = 0, state = IDLE, counter and index = 0.
- rst_n low mid-frame: at the next edge, discard the frame and apply the reset values. No data_valid is generated for the discarded frame.

## Timing
- Let T be the cycle in which the rx_s falling edge is seen in IDLE. rx_s is the value registered 2 edges after rx_in changes.
- Sample instants:
  - Start: T + CLKS_PER_BIT/2.
  - Data bit i (i = 0..3): T + CLKS_PER_BIT/2 + (i+1)·CLKS_PER_BIT.
  - Parity: T + CLKS_PER_BIT/2 + 5·CLKS_PER_BIT.
  - Stop: T + CLKS_PER_BIT/2 + 6·CLKS_PER_BIT.
- data_valid is high in cycle stop sample + 1 only. With the default of 16, that is T + 105.
- From rx_in going low at edge E0 to data_valid high is E0 + 107 cycles at the default of 16.
- busy is high from T+1 through the data_valid cycle inclusive.
- Back-to-back frames: the idle gap may be 0. The next start bit's falling edge is detected in IDLE, at the earliest in the cycle after data_valid. The stop bit lasts a full period, so there is always margin.
- Throughput: one nibble per 7·CLKS_PER_BIT cycles.

## Test plan
- Good even frame: nibble 4'b1011 (LSB first: 1,1,0,1), parity 1, stop 1 → data_out = 4'hB, parity_err = 0, frame_err = 0, a single data_valid exactly 107 cycles after rx_in falls.
- Parity error: nibble 4'b0110 with parity bit 1 → data_out = 4'h6, parity_err = 1, frame_err = 0. With PARITY_ODD = 1, the same frame → parity_err = 0.
- Framing error: nibble 4'hF, parity 0, stop driven 0 → frame_err = 1, data_valid pulses once. Hold the line low for 3 more bit periods → no further data_valid until the line goes high and then low again.
- False start: rx_in low for 3 cycles, then high → busy pulses, returns to IDLE, no data_valid, data_out and flags unchanged from the previous frame.
- Reset mid-frame: assert rst_n low for 1 cycle during data bit 2 → all outputs 0 next cycle. A following clean frame 4'h5 is received correctly with data_valid.
- Back-to-back: frames 4'h3, 4'hC, 4'h0 with zero idle gap → exactly three data_valid pulses spaced 112 cycles apart, all flags 0.
